rtype_rs_execute: RTL and testbench

//  R-type reservation station plus integer ALU, directly downstream of the issue stage.

---
 rtl/tomasulo_pkg.sv | 40 ++++
 rtl/rtype_alu.sv | 41 ++++
 rtl/rtype_rs_execute.sv | 210 +++++++++++++++++++++
 tb/tb_rtype_rs_execute.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tomasulo_pkg
//  Description : Shared widths, internal funct codes and the reservation
//                station entry record used by the execute-side stations.
//  Revision    : 1.0  initial release
// ============================================================================
package tomasulo_pkg;

    localparam int FUNCT_W = 6;
    localparam int TAG_W   = 7;
    localparam int IDX_W   = 11;
    localparam int DATA_W  = 32;

    localparam logic [FUNCT_W-1:0] FN_ADD  = 6'b011011;
    localparam logic [FUNCT_W-1:0] FN_SUB  = 6'b011100;
    localparam logic [FUNCT_W-1:0] FN_SLL  = 6'b011101;
    localparam logic [FUNCT_W-1:0] FN_SLT  = 6'b011110;
    localparam logic [FUNCT_W-1:0] FN_SLTU = 6'b011111;
    localparam logic [FUNCT_W-1:0] FN_XOR  = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_SRL  = 6'b100001;
    localparam logic [FUNCT_W-1:0] FN_SRA  = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_OR   = 6'b100011;
    localparam logic [FUNCT_W-1:0] FN_AND  = 6'b100100;

    typedef struct packed {
        logic               busy;
        logic [FUNCT_W-1:0] funct;
        logic [TAG_W-1:0]   dest_tag;
        logic [IDX_W-1:0]   index;
        logic               s1_valid;
        logic [TAG_W-1:0]   s1_tag;
        logic [DATA_W-1:0]  s1_value;
        logic               s2_valid;
        logic [TAG_W-1:0]   s2_tag;
        logic [DATA_W-1:0]  s2_value;
    } rs_entry_t;

endpackage
`default_nettype wire

// File: rtl/rtype_alu.sv
`default_nettype none
// ============================================================================
//  Module      : rtype_alu
//  Description : Purely combinational integer ALU for R-type funct codes.
//                Ports: funct_i (op select), src1_i/src2_i (operands),
//                result_o (result; unknown codes give 0).
//  Revision    : 1.0  initial release
// ============================================================================
module rtype_alu
    import tomasulo_pkg::*;
(
    input  logic [FUNCT_W-1:0] funct_i,
    input  logic [DATA_W-1:0]  src1_i,
    input  logic [DATA_W-1:0]  src2_i,
    output logic [DATA_W-1:0]  result_o
);

    localparam int SHAMT_W = $clog2(DATA_W);

    logic [SHAMT_W-1:0] w_shamt;
    assign w_shamt = src2_i[SHAMT_W-1:0];

    always_comb begin
        result_o = '0;
        case (funct_i)
            FN_ADD:  result_o = src1_i + src2_i;
            FN_SUB:  result_o = src1_i - src2_i;
            FN_SLL:  result_o = src1_i << w_shamt;
            FN_SRL:  result_o = src1_i >> w_shamt;
            FN_SRA:  result_o = DATA_W'($signed(src1_i) >>> w_shamt);
            FN_SLT:  result_o = {{(DATA_W-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            FN_SLTU: result_o = {{(DATA_W-1){1'b0}}, (src1_i < src2_i)};
            FN_XOR:  result_o = src1_i ^ src2_i;
            FN_OR:   result_o = src1_i | src2_i;
            FN_AND:  result_o = src1_i & src2_i;
            default: result_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rtype_rs_execute.sv
`default_nettype none
// ============================================================================
//  Module      : rtype_rs_execute
//  Description : R-type reservation station with CDB snooping, oldest-ready
//                select through an age matrix, single-cycle ALU and a
//                registered CDB request with valid/ready handshake.
//                Ports: clock/reset_n/flush; issue_* (op in, issue_ready out);
//                cdb_in_* (broadcast snoop); cdb_out_* (result request).
//                Operand/tag/index widths come from tomasulo_pkg.
//  Revision    : 1.0  initial release
// ============================================================================
module rtype_rs_execute
    import tomasulo_pkg::*;
#(
    parameter int RS_DEPTH = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               issue_valid,
    output logic               issue_ready,
    input  logic [FUNCT_W-1:0] issue_funct,
    input  logic [TAG_W-1:0]   issue_dest_tag,
    input  logic [IDX_W-1:0]   issue_index,
    input  logic               issue_src1_valid,
    input  logic [TAG_W-1:0]   issue_src1_tag,
    input  logic [DATA_W-1:0]  issue_src1_value,
    input  logic               issue_src2_valid,
    input  logic [TAG_W-1:0]   issue_src2_tag,
    input  logic [DATA_W-1:0]  issue_src2_value,
    input  logic               cdb_in_valid,
    input  logic [TAG_W-1:0]   cdb_in_tag,
    input  logic [DATA_W-1:0]  cdb_in_value,
    output logic               cdb_out_valid,
    input  logic               cdb_out_ready,
    output logic [TAG_W-1:0]   cdb_out_tag,
    output logic [DATA_W-1:0]  cdb_out_value,
    output logic [IDX_W-1:0]   cdb_out_index
);

    rs_entry_t entry_q [RS_DEPTH];
    rs_entry_t entry_d [RS_DEPTH];
    // age_q[i][j] = 1 means entry i was issued before entry j
    logic [RS_DEPTH-1:0] age_q [RS_DEPTH];
    logic [RS_DEPTH-1:0] age_d [RS_DEPTH];

    logic               out_valid_q, out_valid_d;
    logic [TAG_W-1:0]   out_tag_q,   out_tag_d;
    logic [DATA_W-1:0]  out_value_q, out_value_d;
    logic [IDX_W-1:0]   out_index_q, out_index_d;

    logic [RS_DEPTH-1:0] w_busy, w_ready, w_sel, w_alloc;
    logic                w_alloc_found;
    logic                w_do_issue, w_dispatch;
    rs_entry_t           w_new, w_sel_entry;
    logic [DATA_W-1:0]   w_alu_result;

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_busy[i]  = entry_q[i].busy;
            w_ready[i] = entry_q[i].busy && entry_q[i].s1_valid && entry_q[i].s2_valid;
        end
    end

    // Free-slot status comes only from registered busy bits, so a slot
    // released by this cycle's dispatch is offered again next cycle.
    assign issue_ready = ~&w_busy;
    assign w_do_issue  = issue_valid && issue_ready;

    always_comb begin
        w_alloc       = '0;
        w_alloc_found = 1'b0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (!w_busy[i] && !w_alloc_found) begin
                w_alloc[i]    = 1'b1;
                w_alloc_found = 1'b1;
            end
        end
    end

    // An entry wins when no other ready entry is older than it.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_sel[i] = w_ready[i];
            for (int j = 0; j < RS_DEPTH; j++) begin
                if (j != i && w_ready[j] && age_q[j][i]) begin
                    w_sel[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_sel_entry = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (w_sel[i]) begin
                w_sel_entry = entry_q[i];
            end
        end
    end

    assign w_dispatch = (|w_ready) && (!out_valid_q || cdb_out_ready);

    rtype_alu u_alu (
        .funct_i  (w_sel_entry.funct),
        .src1_i   (w_sel_entry.s1_value),
        .src2_i   (w_sel_entry.s2_value),
        .result_o (w_alu_result)
    );

    // Incoming op, with same-cycle capture of an operand being broadcast now.
    always_comb begin
        w_new          = '0;
        w_new.busy     = 1'b1;
        w_new.funct    = issue_funct;
        w_new.dest_tag = issue_dest_tag;
        w_new.index    = issue_index;
        w_new.s1_tag   = issue_src1_tag;
        w_new.s2_tag   = issue_src2_tag;
        w_new.s1_valid = issue_src1_valid || (cdb_in_valid && cdb_in_tag == issue_src1_tag);
        w_new.s2_valid = issue_src2_valid || (cdb_in_valid && cdb_in_tag == issue_src2_tag);
        w_new.s1_value = issue_src1_valid ? issue_src1_value : cdb_in_value;
        w_new.s2_value = issue_src2_valid ? issue_src2_value : cdb_in_value;
    end

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            entry_d[i] = entry_q[i];
            age_d[i]   = age_q[i];
        end
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (entry_q[i].busy && cdb_in_valid) begin
                if (!entry_q[i].s1_valid && entry_q[i].s1_tag == cdb_in_tag) begin
                    entry_d[i].s1_valid = 1'b1;
                    entry_d[i].s1_value = cdb_in_value;
                end
                if (!entry_q[i].s2_valid && entry_q[i].s2_tag == cdb_in_tag) begin
                    entry_d[i].s2_valid = 1'b1;
                    entry_d[i].s2_value = cdb_in_value;
                end
            end
            if (w_dispatch && w_sel[i]) begin
                entry_d[i].busy = 1'b0;
            end
            if (w_do_issue && w_alloc[i]) begin
                entry_d[i] = w_new;
                // Newest entry: younger than everyone, everyone older than it.
                age_d[i] = '0;
                for (int j = 0; j < RS_DEPTH; j++) begin
                    if (j != i) begin
                        age_d[j][i] = 1'b1;
                    end
                end
            end
        end
        if (flush) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                entry_d[i].busy = 1'b0;
                age_d[i]        = '0;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_tag_d   = out_tag_q;
        out_value_d = out_value_q;
        out_index_d = out_index_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (w_dispatch) begin
            out_valid_d = 1'b1;
            out_tag_d   = w_sel_entry.dest_tag;
            out_value_d = w_alu_result;
            out_index_d = w_sel_entry.index;
        end else if (out_valid_q && cdb_out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                entry_q[i] <= '0;
                age_q[i]   <= '0;
            end
            out_valid_q <= 1'b0;
            out_tag_q   <= '0;
            out_value_q <= '0;
            out_index_q <= '0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
                age_q[i]   <= age_d[i];
            end
            out_valid_q <= out_valid_d;
            out_tag_q   <= out_tag_d;
            out_value_q <= out_value_d;
            out_index_q <= out_index_d;
        end
    end

    assign cdb_out_valid = out_valid_q;
    assign cdb_out_tag   = out_tag_q;
    assign cdb_out_value = out_value_q;
    assign cdb_out_index = out_index_q;

endmodule
`default_nettype wire

// File: tb/tb_rtype_rs_execute.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rtype_rs_execute
//  Description : Self-checking bench for rtype_rs_execute: ALU vector table,
//                hand-written wakeup/ordering/backpressure/flush/reset
//                sequences, and a randomized in-order scoreboard run.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rtype_rs_execute;
    import tomasulo_pkg::*;

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic               flush = 1'b0;
    logic               issue_valid = 1'b0;
    logic               issue_ready;
    logic [FUNCT_W-1:0] issue_funct = '0;
    logic [TAG_W-1:0]   issue_dest_tag = '0;
    logic [IDX_W-1:0]   issue_index = '0;
    logic               issue_src1_valid = 1'b0;
    logic [TAG_W-1:0]   issue_src1_tag = '0;
    logic [DATA_W-1:0]  issue_src1_value = '0;
    logic               issue_src2_valid = 1'b0;
    logic [TAG_W-1:0]   issue_src2_tag = '0;
    logic [DATA_W-1:0]  issue_src2_value = '0;
    logic               cdb_in_valid = 1'b0;
    logic [TAG_W-1:0]   cdb_in_tag = '0;
    logic [DATA_W-1:0]  cdb_in_value = '0;
    logic               cdb_out_valid;
    logic               cdb_out_ready = 1'b1;
    logic [TAG_W-1:0]   cdb_out_tag;
    logic [DATA_W-1:0]  cdb_out_value;
    logic [IDX_W-1:0]   cdb_out_index;

    rtype_rs_execute #(.RS_DEPTH(2)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_funct(issue_funct), .issue_dest_tag(issue_dest_tag), .issue_index(issue_index),
        .issue_src1_valid(issue_src1_valid), .issue_src1_tag(issue_src1_tag), .issue_src1_value(issue_src1_value),
        .issue_src2_valid(issue_src2_valid), .issue_src2_tag(issue_src2_tag), .issue_src2_value(issue_src2_value),
        .cdb_in_valid(cdb_in_valid), .cdb_in_tag(cdb_in_tag), .cdb_in_value(cdb_in_value),
        .cdb_out_valid(cdb_out_valid), .cdb_out_ready(cdb_out_ready),
        .cdb_out_tag(cdb_out_tag), .cdb_out_value(cdb_out_value), .cdb_out_index(cdb_out_index)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [5:0] f, input logic [6:0] tag, input logic [10:0] idx,
                         input logic v1, input logic [6:0] t1, input logic [31:0] d1,
                         input logic v2, input logic [6:0] t2, input logic [31:0] d2);
        issue_funct = f; issue_dest_tag = tag; issue_index = idx;
        issue_src1_valid = v1; issue_src1_tag = t1; issue_src1_value = d1;
        issue_src2_valid = v2; issue_src2_tag = t2; issue_src2_value = d2;
        issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
    endtask

    task automatic drain();
        cdb_out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (!cdb_out_valid) break;
            step();
        end
        chk("drain_done", 64'(cdb_out_valid), 64'd0);
    endtask

    // Reference ALU written straight from the funct-code table.
    function automatic logic [31:0] ref_alu(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (f)
            6'b011011: return a + b;
            6'b011100: return a - b;
            6'b011101: return a << sh;
            6'b100001: return a >> sh;
            6'b100010: return 32'($signed(a) >>> sh);
            6'b011110: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'b011111: return (a < b) ? 32'd1 : 32'd0;
            6'b100000: return a ^ b;
            6'b100011: return a | b;
            6'b100100: return a & b;
            default:   return 32'd0;
        endcase
    endfunction

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[13];

    typedef struct {
        logic [6:0]  tag;
        logic [31:0] val;
        logic [10:0] idx;
    } res_t;
    res_t exp_q[$];

    // Scoreboard monitor: with all operands valid at issue, results must
    // leave in issue order; a stalled request must not change.
    logic        sb_en = 1'b0;
    logic        stall_prev = 1'b0;
    logic [50:0] held = '0;
    initial begin
        forever begin
            @(negedge clock);
            if (sb_en) begin
                if (stall_prev)
                    chk("stall_stable", 64'({cdb_out_valid, cdb_out_tag, cdb_out_value, cdb_out_index}), 64'(held));
                if (cdb_out_valid && cdb_out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_unexpected", 64'(cdb_out_tag), 64'h1_0000);
                    end else begin
                        res_t e;
                        e = exp_q.pop_front();
                        chk("sb_result", 64'({cdb_out_tag, cdb_out_value, cdb_out_index}),
                            64'({e.tag, e.val, e.idx}));
                    end
                end
                stall_prev = cdb_out_valid && !cdb_out_ready;
                held = {cdb_out_valid, cdb_out_tag, cdb_out_value, cdb_out_index};
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    initial begin
        vecs[0]  = '{6'b011011, 32'd5,          32'd7,          32'd12};
        vecs[1]  = '{6'b011100, 32'd3,          32'd5,          32'hFFFF_FFFE};
        vecs[2]  = '{6'b011101, 32'd1,          32'h0000_003F,  32'h8000_0000};
        vecs[3]  = '{6'b100001, 32'h8000_0000,  32'd4,          32'h0800_0000};
        vecs[4]  = '{6'b100010, 32'h8000_0000,  32'd4,          32'hF800_0000};
        vecs[5]  = '{6'b011110, 32'hFFFF_FFFF,  32'd1,          32'd1};
        vecs[6]  = '{6'b011111, 32'hFFFF_FFFF,  32'd1,          32'd0};
        vecs[7]  = '{6'b100000, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_0FF0};
        vecs[8]  = '{6'b100011, 32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF};
        vecs[9]  = '{6'b100100, 32'h0000_00F0,  32'h0000_003C,  32'h0000_0030};
        vecs[10] = '{6'b011011, 32'hFFFF_FFFF,  32'd2,          32'd1};
        vecs[11] = '{6'b000000, 32'd9,          32'd9,          32'd0};
        vecs[12] = '{6'b111111, 32'd9,          32'd9,          32'd0};

        // Reset state
        #12;
        chk("rst_valid", 64'(cdb_out_valid), 64'd0);
        chk("rst_ready", 64'(issue_ready), 64'd1);
        chk("rst_fields", 64'({cdb_out_tag, cdb_out_value, cdb_out_index}), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        step();

        // ALU vector table; vector 0 doubles as the tag=3/index=10 latency case
        for (int i = 0; i < 13; i++) begin
            logic [6:0]  tg;
            logic [10:0] ix;
            tg = (i == 0) ? 7'd3 : 7'(i + 64);
            ix = (i == 0) ? 11'd10 : 11'(i + 100);
            issue(vecs[i].f, tg, ix, 1'b1, 7'd0, vecs[i].a, 1'b1, 7'd0, vecs[i].b);
            chk($sformatf("vec%0d_lat0", i), 64'(cdb_out_valid), 64'd0);
            step();
            chk($sformatf("vec%0d_valid", i), 64'(cdb_out_valid), 64'd1);
            chk($sformatf("vec%0d_value", i), 64'(cdb_out_value), 64'(vecs[i].exp));
            chk($sformatf("vec%0d_tag", i), 64'(cdb_out_tag), 64'(tg));
            chk($sformatf("vec%0d_index", i), 64'(cdb_out_index), 64'(ix));
            step();
        end
        drain();

        // Pending src1 woken two cycles after issue
        issue(6'b011100, 7'd11, 11'd20, 1'b0, 7'd9, 32'd0, 1'b1, 7'd0, 32'd1);
        chk("wake_early", 64'(cdb_out_valid), 64'd0);
        step();
        chk("wake_wait", 64'(cdb_out_valid), 64'd0);
        cdb_in_valid = 1'b1; cdb_in_tag = 7'd9; cdb_in_value = 32'd10;
        step();
        cdb_in_valid = 1'b0;
        chk("wake_notyet", 64'(cdb_out_valid), 64'd0);
        step();
        chk("wake_valid", 64'(cdb_out_valid), 64'd1);
        chk("wake_value", 64'(cdb_out_value), 64'd9);
        step();
        drain();

        // Issue-time bypass from the CDB
        cdb_in_valid = 1'b1; cdb_in_tag = 7'd4; cdb_in_value = 32'h20;
        issue(6'b100100, 7'd12, 11'd21, 1'b0, 7'd4, 32'd0, 1'b1, 7'd0, 32'h30);
        cdb_in_valid = 1'b0;
        step();
        chk("byp_valid", 64'(cdb_out_valid), 64'd1);
        chk("byp_value", 64'(cdb_out_value), 64'h20);
        step();
        drain();

        // Fill both entries, results leave in wake order
        issue(6'b011011, 7'd20, 11'd30, 1'b0, 7'd5, 32'd0, 1'b1, 7'd0, 32'd1);
        issue(6'b011011, 7'd21, 11'd31, 1'b0, 7'd6, 32'd0, 1'b1, 7'd0, 32'd2);
        chk("full_ready", 64'(issue_ready), 64'd0);
        cdb_in_valid = 1'b1; cdb_in_tag = 7'd6; cdb_in_value = 32'd100;
        step();
        cdb_in_tag = 7'd5; cdb_in_value = 32'd200;
        step();
        cdb_in_valid = 1'b0;
        chk("order1", 64'({cdb_out_valid, cdb_out_tag, cdb_out_value}), 64'({1'b1, 7'd21, 32'd102}));
        step();
        chk("order2", 64'({cdb_out_valid, cdb_out_tag, cdb_out_value}), 64'({1'b1, 7'd20, 32'd201}));
        step();
        drain();

        // Older op sitting in the higher-numbered entry must go first
        issue(6'b011011, 7'd30, 11'd40, 1'b1, 7'd0, 32'd1, 1'b1, 7'd0, 32'd1);
        issue(6'b011011, 7'd31, 11'd41, 1'b0, 7'd7, 32'd0, 1'b1, 7'd0, 32'd3);
        chk("age_x", 64'({cdb_out_valid, cdb_out_tag, cdb_out_value}), 64'({1'b1, 7'd30, 32'd2}));
        issue(6'b011011, 7'd32, 11'd42, 1'b0, 7'd7, 32'd0, 1'b1, 7'd0, 32'd4);
        cdb_in_valid = 1'b1; cdb_in_tag = 7'd7; cdb_in_value = 32'd10;
        step();
        cdb_in_valid = 1'b0;
        step();
        chk("age_old", 64'({cdb_out_valid, cdb_out_tag, cdb_out_value}), 64'({1'b1, 7'd31, 32'd13}));
        step();
        chk("age_young", 64'({cdb_out_valid, cdb_out_tag, cdb_out_value}), 64'({1'b1, 7'd32, 32'd14}));
        step();
        drain();

        // Backpressure holds output; release gives back-to-back results
        cdb_out_ready = 1'b0;
        issue(6'b011011, 7'd40, 11'd50, 1'b1, 7'd0, 32'd1, 1'b1, 7'd0, 32'd2);
        issue(6'b011011, 7'd41, 11'd51, 1'b1, 7'd0, 32'd3, 1'b1, 7'd0, 32'd4);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp_hold%0d", k), 64'({cdb_out_valid, cdb_out_tag, cdb_out_value}),
                64'({1'b1, 7'd40, 32'd3}));
            step();
        end
        chk("bp_slot", 64'(issue_ready), 64'd1);
        cdb_out_ready = 1'b1;
        step();
        chk("bp_b2b", 64'({cdb_out_valid, cdb_out_tag, cdb_out_value}), 64'({1'b1, 7'd41, 32'd7}));
        step();
        chk("bp_empty", 64'(cdb_out_valid), 64'd0);

        // Flush under backpressure, then async reset mid-operation
        cdb_out_ready = 1'b0;
        issue(6'b011011, 7'd50, 11'd60, 1'b1, 7'd0, 32'd2, 1'b1, 7'd0, 32'd2);
        issue(6'b011011, 7'd51, 11'd61, 1'b0, 7'd9, 32'd0, 1'b1, 7'd0, 32'd2);
        chk("fl_pre", 64'(cdb_out_valid), 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_valid", 64'(cdb_out_valid), 64'd0);
        chk("fl_ready", 64'(issue_ready), 64'd1);
        cdb_in_valid = 1'b1; cdb_in_tag = 7'd9; cdb_in_value = 32'd1;
        step();
        cdb_in_valid = 1'b0;
        step();
        chk("fl_squashed", 64'(cdb_out_valid), 64'd0);
        issue(6'b011011, 7'd60, 11'd70, 1'b1, 7'd0, 32'd1, 1'b1, 7'd0, 32'd1);
        issue(6'b011011, 7'd61, 11'd71, 1'b0, 7'd12, 32'd0, 1'b1, 7'd0, 32'd1);
        chk("rs_pre", 64'(cdb_out_valid), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rs_valid", 64'(cdb_out_valid), 64'd0);
        chk("rs_ready", 64'(issue_ready), 64'd1);
        chk("rs_fields", 64'({cdb_out_tag, cdb_out_value, cdb_out_index}), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        step();
        step();
        chk("rs_after", 64'({cdb_out_valid, issue_ready}), 64'({1'b0, 1'b1}));

        // Randomized stream checked against the in-order scoreboard
        begin
            logic [5:0] codes[11];
            int tagc;
            int idxc;
            codes = '{6'b011011, 6'b011100, 6'b011101, 6'b100001, 6'b100010, 6'b011110,
                      6'b011111, 6'b100000, 6'b100011, 6'b100100, 6'b000101};
            tagc = 0;
            idxc = 2000;
            sb_en = 1'b1;
            for (int c = 0; c < 400; c++) begin
                cdb_out_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 2) != 0 && issue_ready) begin
                    res_t e;
                    issue_funct      = codes[$urandom_range(0, 10)];
                    issue_dest_tag   = 7'(tagc);
                    issue_index      = 11'(idxc);
                    issue_src1_valid = 1'b1;
                    issue_src2_valid = 1'b1;
                    issue_src1_value = $urandom;
                    issue_src2_value = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom;
                    issue_valid      = 1'b1;
                    e.tag = issue_dest_tag;
                    e.idx = issue_index;
                    e.val = ref_alu(issue_funct, issue_src1_value, issue_src2_value);
                    exp_q.push_back(e);
                    tagc++;
                    idxc++;
                end else begin
                    issue_valid = 1'b0;
                end
                step();
            end
            issue_valid   = 1'b0;
            cdb_out_ready = 1'b1;
            for (int k = 0; k < 50; k++) begin
                if (exp_q.size() == 0 && !cdb_out_valid) break;
                step();
            end
            sb_en = 1'b0;
            chk("rand_leftover", 64'(exp_q.size()), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
